load_store_unit: RTL and testbench

Data-memory responder for the core's MEM stage. It executes the loads and stores that the decoder requests through `memWrite` and the memory register-source select. The unit takes one access per instruction from the pipeline and generates byte strobes and replicated write data from `funct3`. It runs a valid/ready request and response transaction on the data bus, then returns sign- or zero-extended load data. The pipeline is stalled until the access completes.

---
 rtl/load_store_unit.sv | 141 ++++++++++++++
 tb/tb_load_store_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Data-memory responder for the MEM stage: formats stores, runs one valid/ready bus
// transaction per access and returns extended load data. Optional: LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] storeData,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] loadData,
    output logic              accessFault,
    output logic              busReqValid,
    input  logic              busReqReady,
    output logic              busWe,
    output logic [ADDR_W-1:0] busAddr,
    output logic [3:0]        busWstrb,
    output logic [DATA_W-1:0] busWdata,
    input  logic              busRspValid,
    input  logic [DATA_W-1:0] busRdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit MISALIGN_TRAP = 1'b1;
`else
    localparam bit MISALIGN_TRAP = 1'b0;
`endif

    logic [1:0]        state;
    logic              req;
    logic              is_store;
    logic              legal;
    logic              misaligned;
    logic              fault;
    logic [1:0]        off;
    logic [3:0]        strb_fmt;
    logic [DATA_W-1:0] wdata_fmt;
    logic [1:0]        a_q;
    logic [2:0]        f3_q;
    logic              fault_q;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] extracted;

    // Request decode and store formatting for the access presented in IDLE.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        req        = memRead | memWrite;
        is_store   = memWrite;
        legal      = is_store ? (funct3 inside {3'b000, 3'b001, 3'b010})
                              : (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misaligned = 1'b0;
        off        = addr[1:0];
        strb_fmt   = 4'b1111;
        wdata_fmt  = storeData;
        case (funct3[1:0])
            2'b00: begin
                strb_fmt  = 4'b0001 << off;
                wdata_fmt = {4{storeData[7:0]}};
            end
            2'b01: begin
                misaligned = addr[0];
                off        = {addr[1], 1'b0};
                strb_fmt   = 4'b0011 << off;
                wdata_fmt  = {2{storeData[15:0]}};
            end
            default: begin
                misaligned = |addr[1:0];
                off        = 2'b00;
            end
        endcase
        fault = ~legal | (MISALIGN_TRAP & misaligned);
    end

    // Load extraction from the latched offset and funct3.
    always_comb begin
        shifted = busRdata >> {a_q, 3'b000};
        case (f3_q)
            3'b000:  extracted = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  extracted = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  extracted = {24'b0, shifted[7:0]};
            3'b101:  extracted = {16'b0, shifted[15:0]};
            default: extracted = shifted;
        endcase
    end

    assign busReqValid = (state == REQ);
    assign done        = (state == DONE);
    assign accessFault = done & fault_q;
    assign stall       = req & ~done;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: datapath registers are reset too, so bus outputs and loadData read 0 after reset.
        if (rst) begin
            state    <= IDLE;
            a_q      <= 2'b00;
            f3_q     <= 3'b000;
            fault_q  <= 1'b0;
            busWe    <= 1'b0;
            busAddr  <= '0;
            busWstrb <= 4'b0000;
            busWdata <= '0;
            loadData <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: if (req) begin
                    a_q      <= off;
                    f3_q     <= funct3;
                    fault_q  <= fault;
                    loadData <= '0;
                    if (fault) begin
                        state <= DONE;
                    end else begin
                        busWe    <= is_store;
                        busAddr  <= {addr[ADDR_W-1:2], 2'b00};
                        busWstrb <= is_store ? strb_fmt : 4'b0000;
                        busWdata <= is_store ? wdata_fmt : '0;
                        state    <= REQ;
                    end
                end
                REQ:  if (busReqReady) state <= WAIT;
                WAIT: if (busRspValid) begin
                    loadData <= busWe ? '0 : extracted;
                    state    <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized accesses
// checked against a byte-level reference model. Honours LSU_MISALIGN_TRAP_EN.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memRead = 1'b0, memWrite = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0, storeData = '0;
    logic        stall, done, accessFault, busReqValid, busWe;
    logic [31:0] loadData, busAddr, busWdata;
    logic [3:0]  busWstrb;
    logic        busReqReady = 1'b0, busRspValid = 1'b0;
    logic [31:0] busRdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite), .funct3(funct3),
        .addr(addr), .storeData(storeData), .stall(stall), .done(done), .loadData(loadData),
        .accessFault(accessFault), .busReqValid(busReqValid), .busReqReady(busReqReady),
        .busWe(busWe), .busAddr(busAddr), .busWstrb(busWstrb), .busWdata(busWdata),
        .busRspValid(busRspValid), .busRdata(busRdata)
    );

    // Reference model: byte-wise view of one access.
    function automatic void model(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] sd, input logic [31:0] rdv, output bit flt,
                                  output logic [31:0] e_addr, output logic [3:0] e_strb,
                                  output logic [31:0] e_wdata, output logic [31:0] e_ld);
        int     n;
        int     off;
        bit     legal;
        longint val;
        n      = 1 << f3[1:0];
        legal  = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        off    = int'(a[1:0]);
        flt    = !legal;
        e_addr = a & ~32'h3;
        e_strb = 4'b0000;
        e_wdata = '0;
        e_ld   = '0;
        if (legal && (off % n) != 0) begin
`ifdef LSU_MISALIGN_TRAP_EN
            flt = 1'b1;
`else
            off = off - (off % n);
`endif
        end
        if (flt) return;
        if (wr) begin
            for (int i = 0; i < n; i++) e_strb[off + i] = 1'b1;
            for (int i = 0; i < 4; i++) e_wdata[8*i +: 8] = sd[8*(i % n) +: 8];
        end else begin
            val = 0;
            for (int i = 0; i < n; i++) val += longint'(rdv[8*(off + i) +: 8]) << (8*i);
            if (n < 4 && !f3[2] && val >= (longint'(1) << (8*n - 1))) val -= (longint'(1) << (8*n));
            e_ld = val[31:0];
        end
    endfunction

    // Drives one access from an IDLE cycle (called at posedge+1) and acts as the bus slave.
    task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                              input int req_wait, input int rsp_wait,
                              output int done_cyc, output logic flt, output logic [31:0] ld,
                              output logic [31:0] s_addr, output logic [3:0] s_strb,
                              output logic [31:0] s_wdata, output logic s_we,
                              output bit req_seen, output bit stable, output bit stall_ok);
        int req_cnt;
        int rsp_cnt;
        bit in_wait;
        bit hs;
        memRead = rd; memWrite = wr; funct3 = f3; addr = a; storeData = sd; busRdata = rdata;
        done_cyc = -1; flt = 1'bx; ld = 'x;
        s_addr = '0; s_strb = '0; s_wdata = '0; s_we = 1'b0;
        req_seen = 0; stable = 1; stall_ok = 1;
        req_cnt = 0; rsp_cnt = 0; in_wait = 0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            busReqReady = busReqValid && (req_cnt >= req_wait);
            busRspValid = in_wait && (rsp_cnt >= rsp_wait);
            @(negedge clk);
            if (busReqValid) begin
                if (!req_seen) begin
                    s_addr = busAddr; s_strb = busWstrb; s_wdata = busWdata; s_we = busWe;
                end else if (busAddr !== s_addr || busWstrb !== s_strb ||
                             busWdata !== s_wdata || busWe !== s_we) begin
                    stable = 0;
                end
                req_seen = 1;
            end
            if (done === 1'b1) begin
                done_cyc = cyc; flt = accessFault; ld = loadData;
                if (stall !== 1'b0) stall_ok = 0;
            end else if (stall !== 1'b1) begin
                stall_ok = 0;
            end
            hs = busReqValid && busReqReady;
            if (busReqValid) req_cnt++;
            if (in_wait) rsp_cnt++;
            if (busRspValid) in_wait = 0;
            if (hs) in_wait = 1;
            @(posedge clk); #1;
            if (done_cyc >= 0) break;
        end
        memRead = 1'b0; memWrite = 1'b0; busReqReady = 1'b0; busRspValid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({busReqValid, busWe, done, accessFault, stall} !== 5'b0 || busAddr !== 32'h0 ||
            busWstrb !== 4'h0 || busWdata !== 32'h0 || loadData !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got rv=%b we=%b done=%b flt=%b stall=%b addr=%h strb=%b wd=%h ld=%h, want all 0",
                     busReqValid, busWe, done, accessFault, stall, busAddr, busWstrb, busWdata, loadData);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_store_byte();
        int dc; logic f; logic [31:0] ld, sa, sw; logic [3:0] ss; logic we; bit rs, st, sok;
        run_access(0, 1, 3'b000, 32'h1003, 32'hAABBCCDD, 32'h0, 0, 0, dc, f, ld, sa, ss, sw, we, rs, st, sok);
        checks++; if (dc !== 3 || f !== 1'b0) begin errors++; $display("FAIL sb_timing: done_cycle=%0d fault=%b, want 3/0", dc, f); end
        checks++; if (sa !== 32'h1000 || ss !== 4'b1000 || we !== 1'b1) begin errors++;
            $display("FAIL sb_request: addr=%h strb=%b we=%b, want 00001000/1000/1", sa, ss, we); end
        checks++; if (sw !== 32'hDDDDDDDD) begin errors++; $display("FAIL sb_wdata: got %h want DDDDDDDD", sw); end
        checks++; if (!sok) begin errors++; $display("FAIL sb_stall: stall profile wrong"); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busReqValid !== 1'b0) begin errors++;
            $display("FAIL done_pulse: after done cycle done=%b rv=%b, want 0/0", done, busReqValid); end
        @(posedge clk); #1;
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s[3] = '{3'b000, 3'b100, 3'b001};
        logic [31:0] exp[3] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF};
        int dc; logic f; logic [31:0] ld, sa, sw; logic [3:0] ss; logic we; bit rs, st, sok;
        for (int i = 0; i < 3; i++) begin
            run_access(1, 0, f3s[i], 32'h2002, 32'h0, 32'h80FF7F01, 0, 0, dc, f, ld, sa, ss, sw, we, rs, st, sok);
            checks++;
            if (dc !== 3 || f !== 1'b0 || ld !== exp[i] || ss !== 4'b0000 || sa !== 32'h2000) begin
                errors++;
                $display("FAIL load_ext f3=%b: done=%0d fault=%b ld=%h strb=%b addr=%h, want 3/0/%h/0000/00002000",
                         f3s[i], dc, f, ld, ss, sa, exp[i]);
            end
        end
    endtask

    task automatic test_stray_rsp();
        busRdata = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            busRspValid = 1'b1;
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busReqValid !== 1'b0 || stall !== 1'b0 || loadData !== 32'hFFFF80FF) begin
                errors++;
                $display("FAIL stray_rsp: done=%b rv=%b stall=%b ld=%h, want 0/0/0/FFFF80FF", done, busReqValid, stall, loadData);
            end
            @(posedge clk); #1;
        end
        busRspValid = 1'b0;
    endtask

    task automatic test_backpressure();
        int dc; logic f; logic [31:0] ld, sa, sw, rd; logic [3:0] ss; logic we; bit rs, st, sok;
        rd = $urandom;
        run_access(1, 0, 3'b010, 32'h4000, 32'h0, rd, 3, 2, dc, f, ld, sa, ss, sw, we, rs, st, sok);
        checks++; if (dc !== 8) begin errors++; $display("FAIL bp_latency: done_cycle=%0d want 8", dc); end
        checks++; if (!st || !sok) begin errors++; $display("FAIL bp_stability: stable=%0d stall_ok=%0d want 1/1", st, sok); end
        checks++; if (ld !== rd || f !== 1'b0) begin errors++; $display("FAIL bp_data: ld=%h fault=%b want %h/0", ld, f, rd); end
    endtask

    task automatic test_misalign();
        int dc; logic f; logic [31:0] ld, sa, sw, rd; logic [3:0] ss; logic we; bit rs, st, sok;
        rd = $urandom;
        run_access(1, 0, 3'b010, 32'h3002, 32'h0, rd, 0, 0, dc, f, ld, sa, ss, sw, we, rs, st, sok);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (dc !== 1 || f !== 1'b1 || rs !== 1'b0) begin errors++;
            $display("FAIL lw_misalign_trap: done=%0d fault=%b req_seen=%0d want 1/1/0", dc, f, rs); end
`else
        checks++; if (dc !== 3 || f !== 1'b0 || sa !== 32'h3000 || ld !== rd) begin errors++;
            $display("FAIL lw_misalign_align: done=%0d fault=%b addr=%h ld=%h want 3/0/00003000/%h", dc, f, sa, ld, rd); end
`endif
    endtask

    task automatic test_illegal();
        int dc; logic f; logic [31:0] ld, sa, sw; logic [3:0] ss; logic we; bit rs, st, sok;
        run_access(1, 0, 3'b011, 32'h0, 32'h0, 32'h0, 0, 0, dc, f, ld, sa, ss, sw, we, rs, st, sok);
        checks++; if (dc !== 1 || f !== 1'b1 || rs !== 1'b0 || !sok) begin errors++;
            $display("FAIL illegal_load: done=%0d fault=%b req_seen=%0d stall_ok=%0d want 1/1/0/1", dc, f, rs, sok); end
        run_access(0, 1, 3'b100, 32'h10, 32'h55, 32'h0, 0, 0, dc, f, ld, sa, ss, sw, we, rs, st, sok);
        checks++; if (dc !== 1 || f !== 1'b1 || rs !== 1'b0) begin errors++;
            $display("FAIL illegal_store: done=%0d fault=%b req_seen=%0d want 1/1/0", dc, f, rs); end
    endtask

    task automatic test_reset_in_wait();
        int dc; logic f; logic [31:0] ld, sa, sw, rd; logic [3:0] ss; logic we; bit rs, st, sok;
        memRead = 1'b1; funct3 = 3'b010; addr = 32'h5000;
        @(posedge clk); #1;
        busReqReady = 1'b1;
        @(posedge clk); #1;
        busReqReady = 1'b0; memRead = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({busReqValid, busWe, done, accessFault} !== 4'b0 || busAddr !== 32'h0 ||
            busWstrb !== 4'h0 || busWdata !== 32'h0 || loadData !== 32'h0) begin
            errors++;
            $display("FAIL reset_in_wait: rv=%b we=%b done=%b flt=%b addr=%h ld=%h, want all 0",
                     busReqValid, busWe, done, accessFault, busAddr, loadData);
        end
        #2 rst = 1'b0;
        @(posedge clk); #1;
        busRspValid = 1'b1; busRdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if (done !== 1'b0 || busReqValid !== 1'b0 || loadData !== 32'h0) begin errors++;
            $display("FAIL late_rsp: done=%b rv=%b ld=%h want 0/0/0", done, busReqValid, loadData); end
        @(posedge clk); #1;
        busRspValid = 1'b0;
        rd = $urandom;
        run_access(1, 0, 3'b010, 32'h5004, 32'h0, rd, 0, 0, dc, f, ld, sa, ss, sw, we, rs, st, sok);
        checks++; if (dc !== 3 || f !== 1'b0 || ld !== rd || sa !== 32'h5004) begin errors++;
            $display("FAIL post_reset_lw: done=%0d fault=%b ld=%h addr=%h want 3/0/%h/00005004", dc, f, ld, sa, rd); end
    endtask

    task automatic test_random();
        int dc, sel, rw, sw_w; logic f; logic [31:0] ld, sa, swd, rd, a, sd; logic [3:0] ss; logic we;
        bit rs, st, sok, wr, e_f; logic [2:0] f3; logic [31:0] e_a, e_wd, e_ld; logic [3:0] e_s;
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 2); wr = (sel != 0);
            f3 = 3'($urandom_range(0, 7)); a = $urandom; sd = $urandom; rd = $urandom;
            rw = $urandom_range(0, 2); sw_w = $urandom_range(0, 2);
            model(wr, f3, a, sd, rd, e_f, e_a, e_s, e_wd, e_ld);
            run_access(sel != 1, sel != 0, f3, a, sd, rd, rw, sw_w, dc, f, ld, sa, ss, swd, we, rs, st, sok);
            checks++;
            if (dc !== (e_f ? 1 : 3 + rw + sw_w) || f !== e_f || rs !== !e_f || !st || !sok) begin
                errors++;
                $display("FAIL rand%0d_ctrl wr=%0d f3=%b a=%h: done=%0d fault=%b req=%0d stable=%0d stall_ok=%0d want done=%0d fault=%b",
                         i, wr, f3, a, dc, f, rs, st, sok, e_f ? 1 : 3 + rw + sw_w, e_f);
            end else if (!e_f) begin
                checks++;
                if (sa !== e_a || ss !== e_s || we !== wr || ld !== e_ld || (wr && swd !== e_wd)) begin
                    errors++;
                    $display("FAIL rand%0d_data wr=%0d f3=%b a=%h: addr=%h strb=%b we=%b wd=%h ld=%h want %h/%b/%b/%h/%h",
                             i, wr, f3, a, sa, ss, we, swd, ld, e_a, e_s, wr, e_wd, e_ld);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_load_ext();
        test_stray_rsp();
        test_backpressure();
        test_misalign();
        test_illegal();
        test_reset_in_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
